// File: rtl/claa_pkg.sv
// Shared types for the sequential CLAA adder/subtractor.
package claa_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBB = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/claa_seq_alu_claa.sv
// Combinational carry-lookahead adder; also exports group propagate/generate.
module claa #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    input  logic                  c_i,
    output logic [WORD_WIDTH-1:0] s_o,
    output logic                  c_o,
    output logic                  p_o,
    output logic                  g_o
);

    logic [WORD_WIDTH-1:0] w_p;
    logic [WORD_WIDTH-1:0] w_g;
    logic [WORD_WIDTH:0]   w_c;
    logic                  w_gen;

    assign w_p = a_i ^ b_i;
    assign w_g = a_i & b_i;

    // Each carry is the flattened sum-of-products of generate/propagate terms.
    always_comb begin
        logic v_prop;
        logic v_gen;
        logic v_term;
        w_c    = '0;
        w_c[0] = c_i;
        v_gen  = 1'b0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            v_prop = 1'b1;
            for (int unsigned k = 0; k <= i; k++) begin
                v_prop = v_prop & w_p[k];
            end
            v_gen = 1'b0;
            for (int unsigned j = 0; j <= i; j++) begin
                v_term = w_g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    v_term = v_term & w_p[k];
                end
                v_gen = v_gen | v_term;
            end
            w_c[i+1] = v_gen | (v_prop & c_i);
        end
        w_gen = v_gen;
    end

    assign s_o = w_p ^ w_c[WORD_WIDTH-1:0];
    assign c_o = w_c[WORD_WIDTH];
    assign p_o = &w_p;
    assign g_o = w_gen;

endmodule

// File: rtl/claa_seq_alu.sv
// Multi-cycle wide add/subtract: one CHUNK_WIDTH slice per cycle through a
// single CLAA, carry registered between slices, result and flags behind valid/ready.
module claa_seq_alu
    import claa_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  op_t                   op_i,
    input  logic                  c_i,
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WORD_WIDTH-1:0] r_o,
    output logic                  c_o,
    output logic                  v_o,
    output logic                  z_o,
    output logic                  n_o
);

    localparam int N_CHUNKS = WORD_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    if ((WORD_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_width
        $error("claa_seq_alu: WORD_WIDTH must be a multiple of CHUNK_WIDTH");
    end
    if (WORD_WIDTH < 2) begin : g_bad_word
        $error("claa_seq_alu: WORD_WIDTH must be at least 2");
    end

    state_t                 r_state;
    logic [WORD_WIDTH-1:0]  r_a;
    logic [WORD_WIDTH-1:0]  r_b;
    logic                   r_carry;
    logic [IDX_W-1:0]       r_idx;
    logic [WORD_WIDTH-1:0]  r_res;
    logic                   r_ready;
    logic                   r_valid;
    logic [WORD_WIDTH-1:0]  r_out;
    logic                   r_c;
    logic                   r_v;
    logic                   r_z;
    logic                   r_n;

    logic [CHUNK_WIDTH-1:0] w_a_sl;
    logic [CHUNK_WIDTH-1:0] w_b_sl;
    logic [CHUNK_WIDTH-1:0] w_sum;
    logic                   w_c_out;
    logic                   w_c_msb;
    logic [WORD_WIDTH-1:0]  w_res_next;
    logic                   w_b_inv;
    logic                   w_c_init;

    assign w_a_sl = r_a[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign w_b_sl = r_b[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];

    claa #(
        .WORD_WIDTH(CHUNK_WIDTH)
    ) u_claa (
        .a_i(w_a_sl),
        .b_i(w_b_sl),
        .c_i(r_carry),
        .s_o(w_sum),
        .c_o(w_c_out),
        .p_o(),
        .g_o()
    );

    // Carry into the top bit of the slice, recovered from its sum bit; on the
    // last slice this is the word's MSB carry-in used for overflow.
    assign w_c_msb = w_sum[CHUNK_WIDTH-1] ^ w_a_sl[CHUNK_WIDTH-1] ^ w_b_sl[CHUNK_WIDTH-1];

    always_comb begin
        w_res_next = r_res;
        w_res_next[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH] = w_sum;
    end

    assign w_b_inv = (op_i == OP_SUB) || (op_i == OP_SBB);

    always_comb begin
        w_c_init = 1'b0;
        case (op_i)
            OP_ADD:  w_c_init = 1'b0;
            OP_SUB:  w_c_init = 1'b1;
            OP_ADC:  w_c_init = c_i;
            OP_SBB:  w_c_init = c_i;
            default: w_c_init = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_res   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_a     <= a_i;
                        r_b     <= w_b_inv ? ~b_i : b_i;
                        r_carry <= w_c_init;
                        r_idx   <= '0;
                        r_res   <= '0;
                        r_ready <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_c_out;
                    if (r_idx == LAST_IDX) begin
                        r_out   <= w_res_next;
                        r_c     <= w_c_out;
                        r_v     <= w_c_msb ^ w_c_out;
                        r_z     <= (w_res_next == '0);
                        r_n     <= w_res_next[WORD_WIDTH-1];
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign r_o     = r_out;
    assign c_o     = r_c;
    assign v_o     = r_v;
    assign z_o     = r_z;
    assign n_o     = r_n;

endmodule

// File: tb/tb_claa_seq_alu.sv
// Directed bench for claa_seq_alu at 16-bit words, 4-bit slices.
module tb_claa_seq_alu;
    import claa_pkg::*;

    localparam int WW = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic          ready_out;
    op_t           op;
    logic          cin;
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    logic          valid_out;
    logic          ready_in;
    logic [WW-1:0] r;
    logic          c_f;
    logic          v_f;
    logic          z_f;
    logic          n_f;

    int n_checks = 0;
    int n_fail   = 0;

    claa_seq_alu #(
        .WORD_WIDTH(WW),
        .CHUNK_WIDTH(CW)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .valid_i(valid_in),
        .ready_o(ready_out),
        .op_i(op),
        .c_i(cin),
        .a_i(a),
        .b_i(b),
        .valid_o(valid_out),
        .ready_i(ready_in),
        .r_o(r),
        .c_o(c_f),
        .v_o(v_f),
        .z_o(z_f),
        .n_o(n_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, wait (bounded) for valid_o, check latency and results.
    task automatic run_op(input string tag, input op_t o, input logic ci,
                          input logic [WW-1:0] av, input logic [WW-1:0] bv,
                          input logic [WW-1:0] er, input logic ec, input logic ev,
                          input logic ez, input logic en);
        int cyc;
        @(negedge clk);
        op       = o;
        cin      = ci;
        a        = av;
        b        = bv;
        valid_in = 1'b1;
        edge_sample();
        valid_in = 1'b0;
        a        = ~av;
        b        = ~bv;
        cin      = ~ci;
        check({tag, "_ready_busy"}, {31'd0, ready_out}, 32'd0);
        cyc = 0;
        while (!valid_out && cyc < 20) begin
            edge_sample();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd4);
        check({tag, "_r"}, {16'd0, r}, {16'd0, er});
        check({tag, "_flags_cvzn"}, {28'd0, c_f, v_f, z_f, n_f}, {28'd0, ec, ev, ez, en});
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        op       = OP_ADD;
        cin      = 1'b0;
        a        = '0;
        b        = '0;

        edge_sample();
        edge_sample();
        check("rst_ready", {31'd0, ready_out}, 32'd1);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_r", {16'd0, r}, 32'd0);
        check("rst_flags", {28'd0, c_f, v_f, z_f, n_f}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_wrap", OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        edge_sample();
        check("add_wrap_back_idle", {30'd0, ready_out, valid_out}, 32'b10);

        run_op("sub_ovf", OP_SUB, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        edge_sample();
        run_op("adc_ovf", OP_ADC, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        edge_sample();
        run_op("sbb_borrow", OP_SBB, 1'b0, 16'h0005, 16'h0005, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        edge_sample();

        // Backpressure: result must hold while ready_i is low; a new strobe is dropped.
        ready_in = 1'b0;
        run_op("bp", OP_ADD, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        op       = OP_ADD;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge_sample();
            check("bp_hold_valid", {31'd0, valid_out}, 32'd1);
            check("bp_hold_r", {16'd0, r}, 32'h2345);
            check("bp_hold_ready", {31'd0, ready_out}, 32'd0);
        end
        @(negedge clk);
        valid_in = 1'b0;
        ready_in = 1'b1;
        edge_sample();
        check("bp_release", {30'd0, ready_out, valid_out}, 32'b10);
        edge_sample();
        check("bp_no_queue", {30'd0, ready_out, valid_out}, 32'b10);

        // Reset during the second RUN cycle abandons the operation.
        @(negedge clk);
        op       = OP_ADD;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        valid_in = 1'b1;
        edge_sample();
        valid_in = 1'b0;
        edge_sample();
        rst_n = 1'b0;
        edge_sample();
        check("midrun_rst", {30'd0, ready_out, valid_out}, 32'b10);
        @(negedge clk);
        rst_n = 1'b1;
        edge_sample();
        check("midrun_rst_quiet", {30'd0, ready_out, valid_out}, 32'b10);
        run_op("post_rst_add", OP_ADD, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_sample();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
